// File: rtl/jpeg_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// jpeg_frame_sequencer_if
// Control/status bundle between a frame controller (master) and the JPEG
// row-pipeline frame sequencer (slave).
//   start        : frame start pulse
//   num_blocks   : 8x8 blocks in the frame (latched on an accepted start)
//   stall        : freeze request
//   abort        : cancel the running frame
//   core_en      : pipeline stage advance enable
//   address_in   : input row fetch address, in_valid / in_blk_first qualify it
//   address_out  : output row write address, out_valid qualifies it
//   busy         : frame in progress (RUN, DRAIN, DONE)
//   frame_done   : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface jpeg_frame_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [ADDR_W-4:0] num_blocks;
    logic              stall;
    logic              abort;
    logic              core_en;
    logic [ADDR_W-1:0] address_in;
    logic              in_valid;
    logic              in_blk_first;
    logic [ADDR_W-1:0] address_out;
    logic              out_valid;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, num_blocks, stall, abort,
        input  core_en, address_in, in_valid, in_blk_first,
        input  address_out, out_valid, busy, frame_done
    );

    modport slave (
        input  start, num_blocks, stall, abort,
        output core_en, address_in, in_valid, in_blk_first,
        output address_out, out_valid, busy, frame_done
    );
endinterface

// File: rtl/jpeg_frame_sequencer.sv
// ---------------------------------------------------------------------------
// jpeg_frame_sequencer
// Frame-level controller for the JPEG row pipeline. A start in IDLE latches
// the block count and walks the input row address through 8*num_blocks rows
// (RUN), then waits for the last row to leave the PIPE_LAT-deep pipeline
// (DRAIN), pulses frame_done for one cycle (DONE) and returns to IDLE.
// stall freezes every counter and the valid pipeline; abort cancels the
// frame from RUN/DRAIN without a frame_done.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of jpeg_frame_sequencer_if (see interface header)
// ---------------------------------------------------------------------------
module jpeg_frame_sequencer #(
    parameter int ADDR_W   = 15,
    parameter int PIPE_LAT = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    jpeg_frame_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   address_in_q,  address_in_d;
    logic [ADDR_W-1:0]   address_out_q, address_out_d;
    logic [ADDR_W-4:0]   num_blocks_q,  num_blocks_d;
    logic [PIPE_LAT-1:0] valid_sr_q,    valid_sr_d;

    logic [ADDR_W-1:0]   last_row_s;
    logic                adv_s;
    logic                in_valid_s;
    logic                out_valid_s;

    // Per-cycle pipeline controls decoded from the state and stall
    always_comb begin
        last_row_s  = {num_blocks_q, 3'b000} - ADDR_W'(1);
        adv_s       = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !bus.stall;
        in_valid_s  = (state_q == ST_RUN) && !bus.stall;
        // Gated with adv so a row parked in the last stage during a stall is
        // written exactly once.
        out_valid_s = valid_sr_q[PIPE_LAT-1] && adv_s;
    end

    // Next-state, address counters and valid pipeline
    always_comb begin
        state_d       = state_q;
        address_in_d  = address_in_q;
        address_out_d = address_out_q;
        num_blocks_d  = num_blocks_q;
        valid_sr_d    = valid_sr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.num_blocks != '0)) begin
                    num_blocks_d  = bus.num_blocks;
                    address_in_d  = '0;
                    address_out_d = '0;
                    valid_sr_d    = '0;
                    state_d       = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (bus.abort) begin
                    state_d    = ST_IDLE;
                    valid_sr_d = '0;
                end else if (adv_s) begin
                    // Width cast drops the oldest bit; also valid for PIPE_LAT == 1.
                    valid_sr_d = PIPE_LAT'({valid_sr_q, in_valid_s});
                    if (state_q == ST_RUN) begin
                        // The last row address is held rather than wrapped.
                        if (address_in_q == last_row_s) begin
                            state_d = ST_DRAIN;
                        end else begin
                            address_in_d = address_in_q + ADDR_W'(1);
                        end
                    end else if (out_valid_s && (address_out_q == last_row_s)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_q;
                    end
                    if (out_valid_s && (address_out_q != last_row_s)) begin
                        address_out_d = address_out_q + ADDR_W'(1);
                    end else begin
                        address_out_d = address_out_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            address_in_q  <= '0;
            address_out_q <= '0;
            num_blocks_q  <= '0;
            valid_sr_q    <= '0;
        end else begin
            state_q       <= state_d;
            address_in_q  <= address_in_d;
            address_out_q <= address_out_d;
            num_blocks_q  <= num_blocks_d;
            valid_sr_q    <= valid_sr_d;
        end
    end

    assign bus.core_en      = adv_s;
    assign bus.address_in   = address_in_q;
    assign bus.in_valid     = in_valid_s;
    assign bus.in_blk_first = in_valid_s && (address_in_q[2:0] == 3'd0);
    assign bus.address_out  = address_out_q;
    assign bus.out_valid    = out_valid_s;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.frame_done   = (state_q == ST_DONE);
endmodule

// File: doc/jpeg_frame_sequencer.md
Name: jpeg_frame_sequencer

Overview:
- Frame-level controller for the JPEG row pipeline (DCT -> quant -> zigzag -> RLE -> decode -> IZZ -> dequant -> IDCT). It replaces the free-running row counter with a start/stall/abort sequenced frame of programmable length.
- Generates the input row address and the pipeline advance enable.
- Tracks each row through a PIPE_LAT-deep valid pipeline, generates the output row address, and signals frame completion.

Parameters:
ADDR_W, 15, row address width; frame holds up to 8*(2^(ADDR_W-3)-1) rows.
PIPE_LAT, 34, advancing cycles from an input row fetch to its output row; legal range 1 to 255.

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  frame start pulse; honoured only in IDLE with num_blocks != 0
num_blocks  in  ADDR_W-3  number of 8x8 blocks in the frame; latched on an accepted start
stall  in  1  freeze request; no counter or valid pipeline moves while high
abort  in  1  cancels the frame in RUN/DRAIN
core_en  out  1  pipeline stage enable = (state RUN or DRAIN) and not stall
address_in  out  ADDR_W  input row address
in_valid  out  1  row at address_in is fetched this cycle
in_blk_first  out  1  in_valid and address_in[2:0]==0
address_out  out  ADDR_W  output row write address
out_valid  out  1  output row is valid this cycle
busy  out  1  high in RUN, DRAIN and DONE
frame_done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset: state IDLE; address_in, address_out, valid_sr, latched block count, core_en, in_valid, in_blk_first, out_valid, busy and frame_done all 0.
- Definitions:
  - adv = core_en.
  - total = 8*num_blocks_latched.
  - valid_sr is a PIPE_LAT-bit shift register.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - An accepted start latches num_blocks, zeroes address_in, address_out and valid_sr, and enters RUN.
  - start with num_blocks==0 is ignored.
  - start in any other state is ignored.
- RUN:
  - in_valid = not stall.
  - On adv: address_in increments.
  - On adv with address_in == total-1: address_in holds its value and the state goes to DRAIN.
- DRAIN:
  - in_valid = 0.
  - Goes to DONE on the cycle after the out_valid with address_out == total-1.
- DONE: lasts exactly one cycle; frame_done = 1, then IDLE. address_in and address_out hold their values until the next accepted start.
- Valid pipeline:
  - On adv: valid_sr shifts in in_valid.
  - When not adv: valid_sr holds.
  - out_valid = valid_sr[PIPE_LAT-1] and adv, so a stalled row is never written twice.
  - address_out increments after each out_valid.
- Latency: the k-th adv cycle with in_valid produces out_valid on the PIPE_LAT-th following adv cycle.
- No-stall frame timing, start sampled at cycle t:
  - in_valid: cycles t+1 .. t+total.
  - out_valid: cycles t+1+PIPE_LAT .. t+total+PIPE_LAT.
  - frame_done: cycle t+total+PIPE_LAT+1.
- stall:
  - Honoured in every state.
  - In DONE it does not delay the return to IDLE.
- abort:
  - In RUN/DRAIN: next cycle IDLE, valid_sr cleared, no frame_done.
  - Ignored in IDLE/DONE.
  - abort has priority over stall.
- Simultaneous events:
  - reset beats everything.
  - abort and start in the same cycle in RUN: abort wins, start is dropped.
  - start in the DONE cycle is ignored.
- Wrap: address_in and address_out never exceed total-1, so no wrap is possible within a frame.
- Mid-frame reset: same as the reset state; no frame_done.

Test Plan:
- Reset: hold reset 3 cycles with start=1 -> every output 0, state IDLE; after release with start=0, outputs stay 0.
- Basic frame, defaults, num_blocks=2, start at cycle 0, no stall:
  - in_valid cycles 1..16, address_in 0..15; in_blk_first at cycles 1 and 9.
  - out_valid cycles 35..50, address_out 0..15.
  - frame_done only at cycle 51; busy 1 for cycles 1..51, 0 at 52.
- Stall: same frame with stall=1 for cycles 5..7:
  - address_in holds 4 and core_en=0 during the stall.
  - in_valid now ends at 19, out_valid spans 38..53, frame_done at 54.
  - Exactly 16 out_valid pulses.
- Abort: num_blocks=4, abort at cycle 20 -> cycle 21 IDLE, busy 0, out_valid never asserted, no frame_done; a start at 25 restarts with address_in=0 at 26.
- Ignored starts:
  - start with num_blocks=0 -> stays IDLE.
  - start pulses at cycles 3 and 51 during a 2-block frame -> no restart, timing identical to the basic frame.
- Parameters PIPE_LAT=1, ADDR_W=6, num_blocks=7, start at 0:
  - in_valid 1..56, out_valid 2..57, address_out ends at 55, frame_done at 58.
